// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Brief    : Hazard-controller signal bundle. It carries the pipeline hazard
//             inputs, the data-memory handshake and the stall/flush controls.
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
  logic       memRead_ID_EX;
  logic [4:0] rd_ID_EX;
  logic [4:0] rs1_IF_ID;
  logic [4:0] rs2_IF_ID;
  logic       useRs1_IF_ID;
  logic       useRs2_IF_ID;
  logic       redirect_EX;
  logic       memRead_EX_MEM;
  logic       memWrite_EX_MEM;
  logic       dmem_ready;
  logic       dmem_req;
  logic       stall_PC;
  logic       stall_IF_ID;
  logic       stall_ID_EX;
  logic       stall_EX_MEM;
  logic       flush_IF_ID;
  logic       flush_ID_EX;
  logic       flush_MEM_WB;
  logic       mem_err;

  // Hazard controller side: consumes hazard information and drives controls.
  modport master (
    input  memRead_ID_EX, rd_ID_EX, rs1_IF_ID, rs2_IF_ID,
           useRs1_IF_ID, useRs2_IF_ID, redirect_EX,
           memRead_EX_MEM, memWrite_EX_MEM, dmem_ready,
    output dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
           flush_IF_ID, flush_ID_EX, flush_MEM_WB, mem_err
  );

  // Pipeline and data-memory side.
  modport slave (
    output memRead_ID_EX, rd_ID_EX, rs1_IF_ID, rs2_IF_ID,
           useRs1_IF_ID, useRs2_IF_ID, redirect_EX,
           memRead_EX_MEM, memWrite_EX_MEM, dmem_ready,
    input  dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
           flush_IF_ID, flush_ID_EX, flush_MEM_WB, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Stall/flush sequencer for the 5-stage pipeline registers.
//             Handles load-use hazards, EX redirects and multi-cycle data
//             memory accesses (with timeout), and counts stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  pipeline_hazard_ctrl_if.master hif,
  output logic [CNT_W-1:0]      stallCycles
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_acc;
  logic req_raw;
  logic timeout_now;
  logic mem_stall;
  logic load_use;

  // Hazard detection terms shared by the FSM and the output decode.
  always_comb begin
    mem_acc     = hif.memRead_EX_MEM | hif.memWrite_EX_MEM;
    req_raw     = (state_q == MEM_WAIT) | mem_acc;
    timeout_now = (state_q == MEM_WAIT) & ~hif.dmem_ready
                  & (wait_q == TO_W'(MEM_TIMEOUT));
    mem_stall   = req_raw & ~hif.dmem_ready & ~timeout_now;
    load_use    = hif.memRead_ID_EX & (hif.rd_ID_EX != 5'd0)
                  & ((hif.useRs1_IF_ID & (hif.rs1_IF_ID == hif.rd_ID_EX))
                   | (hif.useRs2_IF_ID & (hif.rs2_IF_ID == hif.rd_ID_EX)));
  end

  // State, wait counter, error flag and stall counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory handshake FSM; the stall counter follows the ungated stall term
  // since it is held in reset whenever the outputs are forced low.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_acc && !hif.dmem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hif.dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (timeout_now) begin
          state_d = RUN;
          wait_d  = '0;
          err_d   = 1'b1;
        end else begin
          wait_d  = wait_q + TO_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
    // A memory stall and a load-use stall are the only sources of stall_PC.
    if ((mem_stall || (!hif.redirect_EX && load_use)) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Prioritised stall/flush decode; every control is held low during reset.
  always_comb begin
    hif.dmem_req     = 1'b0;
    hif.stall_PC     = 1'b0;
    hif.stall_IF_ID  = 1'b0;
    hif.stall_ID_EX  = 1'b0;
    hif.stall_EX_MEM = 1'b0;
    hif.flush_IF_ID  = 1'b0;
    hif.flush_ID_EX  = 1'b0;
    hif.flush_MEM_WB = 1'b0;
    if (reset) begin
      hif.dmem_req = req_raw;
      if (mem_stall) begin
        hif.stall_PC     = 1'b1;
        hif.stall_IF_ID  = 1'b1;
        hif.stall_ID_EX  = 1'b1;
        hif.stall_EX_MEM = 1'b1;
        hif.flush_MEM_WB = 1'b1;
      end else if (hif.redirect_EX) begin
        hif.flush_IF_ID  = 1'b1;
        hif.flush_ID_EX  = 1'b1;
      end else if (load_use) begin
        hif.stall_PC     = 1'b1;
        hif.stall_IF_ID  = 1'b1;
        hif.flush_ID_EX  = 1'b1;
      end
    end
  end

  assign hif.mem_err  = err_q;
  assign stallCycles  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Scoreboard bench for pipeline_hazard_ctrl. A driver applies
//             directed then random stimulus and queues the expected response
//             from a reference model; a monitor compares on each falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 3;
  localparam int CNT_W       = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       ld_ex;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       redirect;
    logic       mrd;
    logic       mwr;
    logic       ready;
  } stim_t;

  // ctl = {dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
  //        flush_IF_ID, flush_ID_EX, flush_MEM_WB}
  typedef struct {
    logic [7:0]       ctl;
    logic             err;
    logic [CNT_W-1:0] sc;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] stallCycles;
  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hif        (hif.master),
    .stallCycles(stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: an access in MEM is "outstanding" until memory answers
  // or it has already consumed MEM_TIMEOUT stall cycles.
  bit m_outstanding;
  int m_stalls_used;
  bit m_err;
  int m_sc;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_reset();
    m_outstanding = 1'b0;
    m_stalls_used = 0;
    m_err         = 1'b0;
    m_sc          = 0;
  endtask

  task automatic step(input stim_t s, input bit rst_low);
    exp_t e;
    bit acc, req, tmo, mstall, lu, spc;
    @(posedge clk);
    #1;
    hif.memRead_ID_EX   = s.ld_ex;
    hif.rd_ID_EX        = s.rd;
    hif.rs1_IF_ID       = s.rs1;
    hif.rs2_IF_ID       = s.rs2;
    hif.useRs1_IF_ID    = s.use1;
    hif.useRs2_IF_ID    = s.use2;
    hif.redirect_EX     = s.redirect;
    hif.memRead_EX_MEM  = s.mrd;
    hif.memWrite_EX_MEM = s.mwr;
    hif.dmem_ready      = s.ready;
    reset               = ~rst_low;
    if (rst_low) begin
      model_reset();
      e.ctl = 8'h00;
      e.err = 1'b0;
      e.sc  = '0;
    end else begin
      acc    = s.mrd | s.mwr;
      req    = m_outstanding | acc;
      tmo    = m_outstanding && !s.ready && (m_stalls_used == MEM_TIMEOUT);
      mstall = req && !s.ready && !tmo;
      lu     = s.ld_ex && (s.rd != 0) &&
               ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
      e.err  = m_err;
      e.sc   = m_sc[CNT_W-1:0];
      if (mstall)          e.ctl = {req, 7'b1111001};
      else if (s.redirect) e.ctl = {req, 7'b0000110};
      else if (lu)         e.ctl = {req, 7'b1100010};
      else                 e.ctl = {req, 7'b0000000};
      spc = e.ctl[6];
      if (mstall) begin
        m_outstanding = 1'b1;
        m_stalls_used = m_stalls_used + 1;
      end else begin
        m_outstanding = 1'b0;
        m_stalls_used = 0;
        if (tmo) m_err = 1'b1;
      end
      if (spc && m_sc < CNT_MAX) m_sc = m_sc + 1;
    end
    sb.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hif.dmem_req, hif.stall_PC, hif.stall_IF_ID, hif.stall_ID_EX,
               hif.stall_EX_MEM, hif.flush_IF_ID, hif.flush_ID_EX, hif.flush_MEM_WB};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
        end
        checks++;
        if (hif.mem_err !== e.err) begin
          failures++;
          $display("FAIL mem_err t=%0t actual=%b required=%b", $time, hif.mem_err, e.err);
        end
        checks++;
        if (stallCycles !== e.sc) begin
          failures++;
          $display("FAIL stallCycles t=%0t actual=%0d required=%0d", $time, stallCycles, e.sc);
        end
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    hif.memRead_ID_EX   = 1'b0;
    hif.rd_ID_EX        = '0;
    hif.rs1_IF_ID       = '0;
    hif.rs2_IF_ID       = '0;
    hif.useRs1_IF_ID    = 1'b0;
    hif.useRs2_IF_ID    = 1'b0;
    hif.redirect_EX     = 1'b0;
    hif.memRead_EX_MEM  = 1'b0;
    hif.memWrite_EX_MEM = 1'b0;
    hif.dmem_ready      = 1'b0;
    model_reset();

    // Reset state, with a memory access pending on the inputs.
    s = idle(); s.mrd = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b1);
    step(idle(), 1'b0);

    // Load-use on rs1: one stall cycle, then clear.
    s = idle(); s.ld_ex = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1;
    step(s, 1'b0);
    step(idle(), 1'b0);
    // Load-use on rs2.
    s = idle(); s.ld_ex = 1'b1; s.rd = 5'd9; s.rs2 = 5'd9; s.use2 = 1'b1;
    step(s, 1'b0);
    // rd = x0 and unused source: no hazard.
    s = idle(); s.ld_ex = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.use1 = 1'b1;
    step(s, 1'b0);
    s = idle(); s.ld_ex = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b0;
    step(s, 1'b0);
    // Load-use together with a redirect: redirect wins.
    s = idle(); s.ld_ex = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.use1 = 1'b1; s.redirect = 1'b1;
    step(s, 1'b0);

    // Single-cycle access: no stall.
    s = idle(); s.mwr = 1'b1; s.ready = 1'b1;
    step(s, 1'b0);
    // Three-cycle wait then ready.
    s = idle(); s.mrd = 1'b1; s.ld_ex = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.use1 = 1'b1;
    s.redirect = 1'b1;
    for (int i = 0; i < 3; i++) step(s, 1'b0);
    s.ready = 1'b1;
    step(s, 1'b0);
    step(idle(), 1'b0);

    // Memory never answers: MEM_TIMEOUT stall cycles, then abort.
    s = idle(); s.mrd = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) step(s, 1'b0);
    step(idle(), 1'b0);
    step(idle(), 1'b0);

    // Reset asserted while waiting on memory.
    s = idle(); s.mwr = 1'b1;
    step(s, 1'b0);
    step(s, 1'b0);
    s.ld_ex = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.use1 = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b0);
    step(idle(), 1'b0);

    // Random traffic; resets only early so the stall counter can saturate.
    for (int i = 0; i < 2000; i++) begin
      s.ld_ex    = 1'($urandom_range(0, 1));
      s.rd       = 5'($urandom_range(0, 3));
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.use1     = 1'($urandom_range(0, 1));
      s.use2     = 1'($urandom_range(0, 1));
      s.redirect = ($urandom_range(0, 3) == 0);
      s.mrd      = ($urandom_range(0, 2) == 0);
      s.mwr      = ($urandom_range(0, 4) == 0);
      s.ready    = ($urandom_range(0, 2) == 0);
      step(s, (i < 400) && ($urandom_range(0, 99) == 0));
    end
    step(idle(), 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
